// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: function codes, FSM states, default width.
// Build option SEQ_ALU_DIV_EN enables the iterative divider.
package seq_alu_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [3:0] {
    F_ADD   = 4'd0,
    F_SUB   = 4'd1,
    F_AND   = 4'd2,
    F_OR    = 4'd3,
    F_SLT   = 4'd4,
    F_SHL   = 4'd5,
    F_XOR   = 4'd6,
    F_SLTU  = 4'd7,
    F_MULT  = 4'd8,
    F_MULTU = 4'd9,
    F_DIV   = 4'd10,
    F_DIVU  = 4'd11,
    F_MFHI  = 4'd12,
    F_MFLO  = 4'd13,
    F_MTHI  = 4'd14,
    F_MTLO  = 4'd15
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/seq_alu_if.sv
// Request/result handshake bundle for seq_alu.
// Master drives requests and out_ready; slave returns results and HI/LO.
interface seq_alu_if
  import seq_alu_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             is_zero;
  logic             err;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, func, a, b, out_ready,
    input  in_ready, out_valid, res, is_zero, err, hi, lo
  );

  modport slave (
    input  in_valid, func, a, b, out_ready,
    output in_ready, out_valid, res, is_zero, err, hi, lo
  );
endinterface

// File: rtl/seq_alu_iter.sv
// Shift-add multiplier / restoring divider, one bit per cycle, on magnitudes.
// Divider datapath exists only when SEQ_ALU_DIV_EN is defined.
module seq_alu_iter
  import seq_alu_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_busy,
  input  logic             i_sgn,
`ifdef SEQ_ALU_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_m;
  logic               r_neg;
  logic [WIDTH-1:0]   w_ua, w_ub, w_nhi, w_nlo;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_p;
`ifdef SEQ_ALU_DIV_EN
  logic               r_div, r_negr, r_dz;
  logic [WIDTH-1:0]   r_a, w_dif;
  logic [WIDTH:0]     w_sh;
  logic               w_ge;

  assign w_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge  = w_sh >= {1'b0, r_m};
  assign w_dif = w_sh[WIDTH-1:0] - r_m;
`endif

  assign w_ua = (i_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_ub = (i_sgn && i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign o_last = (r_cnt == CW'(WIDTH-1));

  always_comb begin
    w_nhi = w_sum[WIDTH:1];
    w_nlo = {w_sum[0], r_lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    if (r_div) begin
      w_nhi = w_ge ? w_dif : w_sh[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_ge};
    end
`endif
  end

  // Result is taken from the final step's next-state values
  assign w_p = r_neg ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};

  always_comb begin
    o_hi = w_p[2*WIDTH-1:WIDTH];
    o_lo = w_p[WIDTH-1:0];
`ifdef SEQ_ALU_DIV_EN
    if (r_div) begin
      o_hi = r_negr ? -w_nhi : w_nhi;
      o_lo = r_neg ? -w_nlo : w_nlo;
      if (r_dz) begin
        o_hi = r_a;
        o_lo = '1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_m    <= '0;
      r_neg  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      r_div  <= 1'b0;
      r_negr <= 1'b0;
      r_dz   <= 1'b0;
      r_a    <= '0;
`endif
    end else if (i_start) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= w_ua;
      r_m    <= w_ub;
      r_neg  <= i_sgn && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
`ifdef SEQ_ALU_DIV_EN
      r_div  <= i_div;
      r_negr <= i_sgn && i_a[WIDTH-1];
      r_dz   <= (i_b == '0);
      r_a    <= i_a;
`endif
    end else if (i_busy) begin
      r_cnt  <= r_cnt + 1'b1;
      r_hi   <= w_nhi;
      r_lo   <= w_nlo;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: handshake, FSM, single-cycle ops and HI/LO registers.
// SEQ_ALU_DIV_EN: enables DIV/DIVU; otherwise they return err in one cycle.
module seq_alu
  import seq_alu_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  state_e           r_state, w_nstate;
  func_e            w_func;
  logic             w_in_ready, w_acc, w_multi, w_last, w_err1;
  logic             r_out_valid, r_err;
  logic [WIDTH-1:0] r_res, r_hi, r_lo;
  logic [WIDTH-1:0] w_res1, w_it_hi, w_it_lo;

  assign w_func     = func_e'(bus.func);
  assign w_in_ready = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
  assign w_acc      = bus.in_valid && w_in_ready;
`ifdef SEQ_ALU_DIV_EN
  assign w_multi    = (bus.func[3:2] == 2'b10);
`else
  assign w_multi    = (bus.func[3:1] == 3'b100);
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.res       = r_res;
  assign bus.is_zero   = (r_res == '0);
  assign bus.err       = r_err;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_acc && w_multi),
    .i_busy  (r_state == BUSY),
    .i_sgn   (!bus.func[0]),
`ifdef SEQ_ALU_DIV_EN
    .i_div   (bus.func[1]),
`endif
    .i_a     (bus.a),
    .i_b     (bus.b),
    .o_last  (w_last),
    .o_hi    (w_it_hi),
    .o_lo    (w_it_lo)
  );

  always_comb begin
    w_res1 = '0;
    w_err1 = 1'b0;
    unique case (w_func)
      F_ADD:  w_res1 = bus.a + bus.b;
      F_SUB:  w_res1 = bus.a - bus.b;
      F_AND:  w_res1 = bus.a & bus.b;
      F_OR:   w_res1 = bus.a | bus.b;
      F_XOR:  w_res1 = bus.a ^ bus.b;
      F_SLT:  w_res1 = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      F_SLTU: w_res1 = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      F_SHL:  w_res1 = bus.b << (WIDTH/2);
      F_MFHI: w_res1 = r_hi;
      F_MFLO: w_res1 = r_lo;
      F_MTHI: w_res1 = bus.a;
      F_MTLO: w_res1 = bus.a;
`ifndef SEQ_ALU_DIV_EN
      F_DIV:  w_err1 = 1'b1;
      F_DIVU: w_err1 = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE:    if (w_acc && w_multi) w_nstate = BUSY;
      BUSY:    if (w_last) w_nstate = DONE;
      DONE:    if (bus.out_ready) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_err       <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else if (w_acc && !w_multi) begin
      r_out_valid <= 1'b1;
      r_res       <= w_res1;
      r_err       <= w_err1;
      if (w_func == F_MTHI) r_hi <= bus.a;
      if (w_func == F_MTLO) r_lo <= bus.a;
    end else if (r_state == BUSY && w_last) begin
      r_out_valid <= 1'b1;
      r_res       <= w_it_lo;
      r_err       <= 1'b0;
      r_hi        <= w_it_hi;
      r_lo        <= w_it_lo;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): driver pushes expected results,
// monitor pops and compares on each out_valid && out_ready transfer.
module tb_seq_alu;
  import seq_alu_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         err;
    int           acc;
    int           lat;
    string        nm;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int wt;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic saw;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", bus.out_valid, 1'b0);
      end else begin
        me = q.pop_front();
        chk({me.nm, "_res"}, bus.res, me.res);
        chk({me.nm, "_zero"}, bus.is_zero, me.res == '0);
        chk({me.nm, "_err"}, bus.err, me.err);
        chk({me.nm, "_hi"}, bus.hi, me.hi);
        chk({me.nm, "_lo"}, bus.lo, me.lo);
        if (me.lat != 0) chk({me.nm, "_lat"}, W'(cyc - me.acc), W'(me.lat));
      end
    end
  end

  task automatic send(input logic [3:0] f, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] r,
                      input logic [W-1:0] hi, input logic [W-1:0] lo,
                      input logic e, input int lat, input string nm,
                      input bit push, output int waited);
    int bud;
    exp_t x;
    bud = 200;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func = f;
    bus.a = a;
    bus.b = b;
    #1;
    while (!bus.in_ready && bud > 0) begin
      @(negedge clk);
      #1;
      bud--;
    end
    waited = 200 - bud;
    if (!bus.in_ready) begin
      chk({nm, "_accept_timeout"}, bus.in_ready, 1'b1);
    end else if (push) begin
      x.res = r; x.hi = hi; x.lo = lo; x.err = e;
      x.acc = cyc; x.lat = lat; x.nm = nm;
      q.push_back(x);
      m_hi = hi;
      m_lo = lo;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic op1(input func_e f, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] r,
                     input string nm);
    int w;
    send(f, a, b, r, m_hi, m_lo, 1'b0, 1, nm, 1'b1, w);
  endtask

  task automatic drain();
    int bud;
    bud = 200;
    while (q.size() != 0 && bud > 0) begin
      @(posedge clk);
      bud--;
    end
    if (q.size() != 0) chk("drain_timeout", W'(q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.func = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_res", bus.res, '0);
    chk("rst_is_zero", bus.is_zero, 1'b1);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_hi", bus.hi, '0);
    chk("rst_lo", bus.lo, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);

    op1(F_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         "add_wrap");
    op1(F_SUB,  32'h5,         32'h7,         32'hFFFF_FFFE, "sub_wrap");
    op1(F_AND,  32'hF0F0_00FF, 32'h0FF0_FF0F, 32'h00F0_000F, "and");
    op1(F_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, "or");
    op1(F_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, "xor");
    op1(F_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         "slt");
    op1(F_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         "sltu");
    op1(F_SHL,  32'h0,         32'h0000_1234, 32'h1234_0000, "shl");

    send(F_MTHI, 32'h1234, 32'h0, 32'h1234, 32'h1234, m_lo, 1'b0, 1,
         "mthi", 1'b1, wt);
    send(F_MFHI, 32'h0, 32'h0, 32'h1234, m_hi, m_lo, 1'b0, 1,
         "mfhi", 1'b1, wt);
    chk("mfhi_back_to_back", W'(wt), '0);
    send(F_MTLO, 32'hABCD, 32'h0, 32'hABCD, m_hi, 32'hABCD, 1'b0, 1,
         "mtlo", 1'b1, wt);
    op1(F_MFLO, 32'h0, 32'h0, 32'hABCD, "mflo");

    send(F_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, 32'hFFFF_FFFF,
         32'hFFFF_FFEB, 1'b0, 33, "mult", 1'b1, wt);
    send(F_MULTU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h1,
         32'hFFFF_FFFE, 1'b0, 33, "multu", 1'b1, wt);
`ifdef SEQ_ALU_DIV_EN
    send(F_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
         32'hFFFF_FFFD, 1'b0, 33, "div_neg", 1'b1, wt);
    send(F_DIVU, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h5,
         32'hFFFF_FFFF, 1'b0, 33, "divu_by0", 1'b1, wt);
    send(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,
         32'h8000_0000, 1'b0, 33, "div_ovf", 1'b1, wt);
    send(F_DIVU, 32'd100, 32'd7, 32'd14, 32'd2,
         32'd14, 1'b0, 33, "divu", 1'b1, wt);
`else
    send(F_DIV, 32'hFFFF_FFF9, 32'h2, 32'h0, m_hi, m_lo, 1'b1, 1,
         "div_off", 1'b1, wt);
    send(F_DIVU, 32'h5, 32'h0, 32'h0, m_hi, m_lo, 1'b1, 1,
         "divu_off", 1'b1, wt);
`endif
    drain();

    bus.out_ready = 1'b0;
    send(F_ADD, 32'd3, 32'd4, 32'd7, m_hi, m_lo, 1'b0, 0,
         "hold_add", 1'b1, wt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_out_valid", bus.out_valid, 1'b1);
      chk("hold_res", bus.res, 32'd7);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.func = F_SUB;
    bus.a = 32'd10;
    bus.b = 32'd4;
    #1;
    chk("release_in_ready", bus.in_ready, 1'b1);
    me.res = 32'd6; me.hi = m_hi; me.lo = m_lo; me.err = 1'b0;
    me.acc = cyc; me.lat = 1; me.nm = "release_sub";
    q.push_back(me);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();

    send(F_MULTU, 32'd5, 32'd6, 32'd30, 32'd0, 32'd30, 1'b0, 33,
         "multu_abort", 1'b0, wt);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_hi", bus.hi, '0);
    chk("abort_lo", bus.lo, '0);
    chk("abort_res", bus.res, '0);
    m_hi = '0;
    m_lo = '0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) saw = 1'b1;
    end
    chk("no_stale_result", saw, 1'b0);
    op1(F_ADD, 32'd2, 32'd3, 32'd5, "post_rst_add");
    op1(F_MFHI, 32'h0, 32'h0, 32'h0, "post_rst_mfhi");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; even, >= 8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 func  input  4  operation code (see REQ-010).
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 out_valid / out_ready  output 1 / input 1  result handshake.
REQ-009 res  output WIDTH  result; is_zero  output 1  (res == 0); err  output 1  unsupported func; hi, lo  output WIDTH each  architectural HI/LO registers.

Function
REQ-010 func codes: 0 add, 1 sub, 2 and, 3 or, 4 slt signed, 5 b << WIDTH/2, 6 xor, 7 sltu, 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 MFHI, 13 MFLO, 14 MTHI, 15 MTLO.
REQ-011 Request accepted on a cycle with in_valid && in_ready; a, b, func captured then.
REQ-012 in_ready = (state == IDLE) && (!out_valid || out_ready); back-to-back single-cycle ops at one per cycle.
REQ-013 Codes 0-7, 12-15: res registered, out_valid high the cycle after acceptance (latency 1).
REQ-014 add/sub wrap modulo 2^WIDTH; slt/sltu produce 0 or 1 zero-extended.
REQ-015 MFHI/MFLO: res = hi / lo. MTHI/MTLO: hi / lo = a at the acceptance edge, res = a.
REQ-016 MULT/MULTU: iterative shift-add, one bit per cycle; {hi,lo} = full 2*WIDTH product, signed for 8 (two's-complement), unsigned for 9.
REQ-017 DIV/DIVU: iterative restoring divide, one bit per cycle; lo = quotient truncated toward zero, hi = remainder with sign of a (signed).
REQ-018 Multi-cycle ops: out_valid exactly WIDTH+1 cycles after acceptance; res = lo; hi/lo update on the same edge out_valid rises.
REQ-019 Divide by zero: lo = all ones, hi = a; no err.
REQ-020 Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0.
REQ-021 out_valid, res, is_zero, err held stable while out_valid && !out_ready.
REQ-022 State machine: IDLE -> BUSY on accepted code 8-11; BUSY counts WIDTH cycles -> DONE; DONE -> IDLE when out_ready && out_valid; single-cycle ops stay in IDLE.
REQ-023 in_valid ignored when in_ready low; no request is queued.
REQ-024 hi/lo not modified by codes 0-7 or 12-13.

Reset
REQ-025 rst_n low: immediately state = IDLE, out_valid = 0, res = 0, is_zero = 1, err = 0, hi = 0, lo = 0, iteration counter = 0.
REQ-026 Reset during BUSY aborts operation; no partial result reaches hi/lo/res.
REQ-027 in_ready = 1 on the first clock after rst_n deasserts.

Configuration
REQ-028 Macro SEQ_ALU_DIV_EN: defined -> codes 10/11 per REQ-017..020.
REQ-029 Undefined -> no divider logic; codes 10/11 complete with latency 1, res = 0, err = 1, hi/lo unchanged; all other codes unaffected.

Structure
REQ-030 Package seq_alu_pkg holds func code constants/enum, state enum (IDLE, BUSY, DONE), and default WIDTH constant.
REQ-031 Sub-module seq_alu_iter holds the shift-add/shift-subtract datapath and iteration counter; seq_alu holds handshake, FSM, single-cycle ops, hi/lo.

Verification (WIDTH = 32)
REQ-032 add a=0xFFFFFFFF b=1 -> next cycle out_valid=1, res=0, is_zero=1.
REQ-033 MULT a=-3 b=7 -> out_valid after 33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFEB, res=lo.
REQ-034 DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5; without SEQ_ALU_DIV_EN -> err=1, latency 1.
REQ-035 out_ready held low 5 cycles after result -> res/out_valid stable, in_ready=0; then out_ready=1 with new sub request -> accepted same cycle.
REQ-036 rst_n pulsed low at cycle 10 of MULTU -> out_valid=0, hi=lo=0 immediately; no stale result after release.
REQ-037 MTHI a=0x1234 then MFHI -> res=0x1234 on consecutive cycles, in_ready continuously high.
